// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/mc_if.sv
// Bundle between controller and datapath: instruction fields in, control strobes out.
// Latency: n/a (wiring only).
// Backpressure: none; controls are level signals valid every cycle.
interface mc_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    // Datapath side: supplies instruction fields and zero flag, consumes controls.
    modport master (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, state
    );

    // Controller side.
    modport slave (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU operation decoder: maps the FSM's aluop class plus funct to an ALU code.
// Latency: purely combinational.
// Backpressure: none.
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    // Fixed add/sub for address and branch work; funct only matters for R-type.
    always_comb begin
        o_alucontrol = ALUCTL_ADD;
        case (i_aluop)
            ALUOP_SUB:   o_alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_SUB: o_alucontrol = ALUCTL_SUB;
                    FUNCT_AND: o_alucontrol = ALUCTL_AND;
                    FUNCT_OR:  o_alucontrol = ALUCTL_OR;
                    FUNCT_SLT: o_alucontrol = ALUCTL_SLT;
                    default:   o_alucontrol = ALUCTL_ADD;
                endcase
            end
            default:     o_alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset controller: Moore FSM sequencing fetch/decode/execute steps.
// Latency: 2-5 cycles per instruction depending on opcode; pcen/alucontrol combinational.
// Backpressure: none; advances one state per clock, reset forces FETCH synchronously.
module mc_controller
    import mc_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    mc_if.slave     bus
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite;
    logic       w_branch;
    logic [1:0] w_aluop;

    // State register; reset is sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state and Moore outputs; anything not set in a state stays 0.
    always_comb begin
        w_next       = S_FETCH;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_aluop      = ALUOP_ADD;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.iord     = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.pcsrc    = 2'b00;
        case (r_state)
            S_FETCH: begin
                bus.irwrite = 1'b1;
                w_pcwrite   = 1'b1;
                bus.alusrcb = 2'b01;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                w_next      = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                w_aluop     = ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                w_aluop     = ALUOP_SUB;
                bus.pcsrc   = 2'b01;
                w_branch    = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
            end
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Branch-taken needs the same-cycle zero flag, so pcen is not purely Moore.
    assign bus.pcen  = w_pcwrite | (w_branch & bus.zero);
    assign bus.state = r_state;

    aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (bus.funct),
        .o_alucontrol (bus.alucontrol)
    );

endmodule
